sevenseg_reader: RTL

Captures a multiplexed, active-low seven-segment display bus (segment lines plus digit anode enables) and recovers the displayed digits as BCD/hex nibbles. It is the receive end of our display path: it sits on the pins driven by the segment decoder and scan mux, and is used for loopback self-test and for reading displays on external boards. Each digit is filtered for stability, a frame is assembled once every digit has been refreshed, and the frame is presented on a valid/ready handshake.

---
 rtl/sevenseg_reader.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sevenseg_reader.sv
// sevenseg_reader
// Receive side of the multiplexed seven-segment display path. It samples an
// active-low segment bus and its active-low digit enables, filters each digit
// for stability, and collects one accepted value per digit into a staging
// frame. Once every digit has been refreshed, the frame goes out on a
// valid/ready handshake.
//
// Parameters:
//   NUM_DIGITS    - digits on the bus (1..8)
//   STABLE_CYCLES - identical consecutive samples needed to accept a digit (1..255)
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   seg[6:0]     in   segment lines, active-low, GFEDCBA (bit0 = A)
//   an[N-1:0]    in   digit enables, active-low, bit i = digit i
//   frame_valid  out  frame_* outputs hold a complete frame
//   frame_ready  in   consumer accepts the frame
//   frame_digits out  nibble i = digit i (digit 0 in bits [3:0])
//   frame_blank  out  digit i was dark
//   frame_inv    out  digit i showed an undecodable pattern
//   anode_err    out  one-cycle pulse, more than one anode was active
//   overrun      out  one-cycle pulse, a completed frame was dropped
//
// Build option: define SEVENSEG_READER_HEX_EN to also decode the letters A-F.
// Without it those six patterns are reported as invalid.

module sevenseg_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [6:0]                seg,
  input  logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_valid,
  input  logic                      frame_ready,
  output logic [4*NUM_DIGITS-1:0]   frame_digits,
  output logic [NUM_DIGITS-1:0]     frame_blank,
  output logic [NUM_DIGITS-1:0]     frame_inv,
  output logic                      anode_err,
  output logic                      overrun
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  // Segment pattern to {inv, blank, nibble}.
  function automatic logic [5:0] decode(input logic [6:0] p);
    case (p)
      7'b1000000: decode = {2'b00, 4'h0};
      7'b1111001: decode = {2'b00, 4'h1};
      7'b0100100: decode = {2'b00, 4'h2};
      7'b0110000: decode = {2'b00, 4'h3};
      7'b0011001: decode = {2'b00, 4'h4};
      7'b0010010: decode = {2'b00, 4'h5};
      7'b0000010: decode = {2'b00, 4'h6};
      7'b1111000: decode = {2'b00, 4'h7};
      7'b0000000: decode = {2'b00, 4'h8};
      7'b0010000: decode = {2'b00, 4'h9};
`ifdef SEVENSEG_READER_HEX_EN
      7'b0001000: decode = {2'b00, 4'hA};
      7'b0000011: decode = {2'b00, 4'hB};
      7'b1000110: decode = {2'b00, 4'hC};
      7'b0100001: decode = {2'b00, 4'hD};
      7'b0000110: decode = {2'b00, 4'hE};
      7'b0001110: decode = {2'b00, 4'hF};
`endif
      7'b1111111: decode = {2'b01, 4'h0};
      default:    decode = {2'b10, 4'h0};
    endcase
  endfunction

  logic [IW-1:0]          prev_idx;
  logic [6:0]             prev_pat;
  logic [7:0]             run;
  logic [7:0]             run_next;
  logic [IW-1:0]          idx;
  logic [3:0]             low_cnt;
  logic                   valid_smp;
  logic                   err_smp;
  logic                   same;
  logic                   accept;
  logic                   complete;
  logic [5:0]             dec;
  logic [NUM_DIGITS-1:0]  seen;
  logic [NUM_DIGITS-1:0]  seen_set;
  logic [NUM_DIGITS-1:0]  seen_next;
  logic [4*NUM_DIGITS-1:0] stage_digits;
  logic [NUM_DIGITS-1:0]  stage_blank;
  logic [NUM_DIGITS-1:0]  stage_inv;

  // Classify the anode bus: count active enables and find the selected digit.
  always_comb begin
    low_cnt = 4'd0;
    idx     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      low_cnt = low_cnt + {3'd0, ~an[i]};
      idx     = an[i] ? idx : IW'(i);
    end
    valid_smp = (low_cnt == 4'd1);
    err_smp   = (low_cnt > 4'd1);
  end

  // Run counter update and one-shot acceptance detection.
  always_comb begin
    dec = decode(seg);
    // run != 0 means the previous sample was valid, so prev_* are meaningful.
    same = valid_smp && (run != 8'd0) && (idx == prev_idx) && (seg == prev_pat);
    if (same) begin
      run_next = (run == 8'hFF) ? run : run + 8'd1;
    end else if (valid_smp) begin
      run_next = 8'd1;
    end else begin
      run_next = 8'd0;
    end
    // A saturated run that stays at 255 must not re-accept.
    accept   = valid_smp && (run_next == STABLE) && !(same && (run == 8'hFF));
    complete = &seen;
    seen_set = NUM_DIGITS'(accept) << idx;
    // Completion clears seen on the same edge that a new acceptance may set a bit.
    seen_next = (complete ? '0 : seen) | seen_set;
  end

  // Sampler state: last valid index/pattern and the saturating run length.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_idx <= '0;
      prev_pat <= 7'd0;
      run      <= 8'd0;
    end else begin
      run <= run_next;
      if (valid_smp) begin
        prev_idx <= idx;
        prev_pat <= seg;
      end
    end
  end

  // Staging frame and per-digit refresh tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seen         <= '0;
      stage_digits <= '0;
      stage_blank  <= '0;
      stage_inv    <= '0;
    end else begin
      seen <= seen_next;
      if (accept) begin
        stage_digits[idx*4 +: 4] <= dec[3:0];
        stage_blank[idx]         <= dec[4];
        stage_inv[idx]           <= dec[5];
      end
    end
  end

  // Output frame, handshake and status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_valid  <= 1'b0;
      frame_digits <= '0;
      frame_blank  <= '0;
      frame_inv    <= '0;
      anode_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      anode_err <= err_smp;
      overrun   <= complete && frame_valid && !frame_ready;
      if (complete && (!frame_valid || frame_ready)) begin
        frame_valid  <= 1'b1;
        frame_digits <= stage_digits;
        frame_blank  <= stage_blank;
        frame_inv    <= stage_inv;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule
